filter_switch_declicker: RTL
============================

// Module: filter_switch_declicker
//
// PURPOSE
//  Sits between SWITCH/FIR and the I2S2 transceiver TX path.
//  - Debounces the user filter-select switches.
//  - Forwards the selection to the FIR only while the audio is muted.
//  - Ramps the FIR output gain down before a coefficient change and back up after.
//  Removes the clicks caused by abrupt coefficient swaps and by FIR pipeline flush.
//
// PARAMETERS
//  GAIN_W       8   gain fraction bits; unity gain UNITY = 2**GAIN_W (=256)
//  STEP         4   gain change per frame while ramping (UNITY/STEP = 64 frames per ramp)
//  HOLD_FRAMES  32  frames held fully muted after SWITCH_OUT changes (FIR flush)
//  DEB_FRAMES   16  frames SWITCH_IN must be stable before it is accepted
//
// PORTS
//  MCLK           in   1   system audio clock; all logic on posedge
//  RESET          in   1   synchronous, active-high reset
//  SWITCH_IN      in   4   raw board switches (asynchronous to MCLK)
//  LEFT_RX_READY  in   1   1-MCLK frame strobe from transceiver; all frame counting uses it
//  RIGHT_IN       in   24  signed right sample from FIR
//  LEFT_IN        in   24  signed left sample from FIR
//  SWITCH_OUT     out  4   filter select driven to FIR
//  RIGHT_OUT      out  24  signed gained right sample to transceiver TX
//  LEFT_OUT       out  24  signed gained left sample to transceiver TX
//  MUTED          out  1   high while GAIN == 0
//
// BEHAVIOUR
//  Sync and debounce
//   - SWITCH_IN passes through a 2-flop synchroniser.
//   - The debounce counter increments on each frame strobe while the synced value equals the candidate.
//   - Any difference reloads the candidate and clears the counter.
//   - At DEB_FRAMES the candidate becomes PENDING.
//  FSM states: PASS, RAMP_DN, HOLD, RAMP_UP. GAIN is an unsigned register 0..UNITY.
//   - PASS:    GAIN = UNITY. PENDING != SWITCH_OUT -> RAMP_DN.
//   - RAMP_DN: on each strobe GAIN = max(GAIN-STEP, 0).
//              When GAIN reaches 0 -> HOLD; SWITCH_OUT <= PENDING on that same edge; hold count = 0.
//   - HOLD:    GAIN = 0; the count increments on each strobe.
//              If PENDING != SWITCH_OUT: SWITCH_OUT <= PENDING and the count restarts at 0.
//              Count == HOLD_FRAMES-1 on a strobe -> RAMP_UP.
//   - RAMP_UP: on each strobe GAIN = min(GAIN+STEP, UNITY); at UNITY -> PASS.
//              If PENDING != SWITCH_OUT -> RAMP_DN from the current GAIN (no jump).
//  Arithmetic
//   - OUT = (IN * $signed({1'b0,GAIN})) >>> GAIN_W, taking the low 24 bits.
//   - Arithmetic shift truncates toward -inf.
//   - Overflow is impossible since GAIN <= UNITY; UNITY gives exact pass-through.
//  Timing and boundaries
//   - Outputs are registered, latency 1 MCLK, updated every MCLK cycle (not only on strobes).
//   - MUTED, GAIN and SWITCH_OUT change only on strobe edges.
//   - Strobe on the same edge as a PENDING change: the FSM sees the old PENDING.
//   - A GAIN not divisible by STEP saturates at 0 or UNITY; it never wraps.
//   - A SWITCH_IN glitch shorter than DEB_FRAMES frames never reaches PENDING.
//   - RESET mid-ramp applies the reset state on the next edge, with no ramp.
//  Reset values (SOFT_START_EN defined)
//   - SWITCH_OUT = 0, PENDING = 0, RIGHT_OUT = LEFT_OUT = 0.
//   - State HOLD, GAIN = 0, MUTED = 1, counters = 0.
//
// CONFIGURATION
//  SOFT_START_EN
//   - Defined: reset enters HOLD with GAIN = 0, giving a muted power-up followed by a fade-in.
//   - Undefined: reset enters PASS with GAIN = UNITY and MUTED = 0; SWITCH_OUT and outputs still reset to 0.
//
// TESTING
//  1 Reset, SOFT_START_EN, LEFT_IN = 24'h100000, strobe every 64 MCLK
//    -> MUTED=1 for 32 frames; LEFT_OUT rises 4/256 per frame; 24'h100000 after 64 more frames.
//  2 PASS, SWITCH_IN 0->5 held
//    -> SWITCH_OUT unchanged for 16 frames + sync; ramp down 64 frames; SWITCH_OUT=5 exactly when GAIN hits 0.
//  3 SWITCH_IN pulse of 0->3 for 10 frames then back to 0 -> no state change; GAIN stays 256.
//  4 Switch change during RAMP_UP at GAIN=128
//    -> ramp down starts from 128; GAIN never jumps; SWITCH_OUT updates only at GAIN=0.
//  5 GAIN=256, LEFT_IN = -24'sd1 and 24'sh7FFFFF -> same values out 1 MCLK later;
//    at GAIN=128 -> -1 and 24'sh3FFFFF.
//  6 RESET pulsed mid RAMP_DN at GAIN=100
//    -> next edge: reset values per macro setting; outputs 0 one cycle after RESET.

Source files
------------

// File: rtl/filter_switch_declicker.sv
// rtl/filter_switch_declicker.sv - debounced filter select with gain ramp around coefficient swaps
// Optional feature macro: SOFT_START_EN (muted power-up followed by a fade-in)
module filter_switch_declicker #(
  parameter int GAIN_W      = 8,
  parameter int STEP        = 4,
  parameter int HOLD_FRAMES = 32,
  parameter int DEB_FRAMES  = 16
) (
  input  logic               MCLK,
  input  logic               RESET,
  input  logic [3:0]         SWITCH_IN,
  input  logic               LEFT_RX_READY,
  input  logic signed [23:0] RIGHT_IN,
  input  logic signed [23:0] LEFT_IN,
  output logic [3:0]         SWITCH_OUT,
  output logic signed [23:0] RIGHT_OUT,
  output logic signed [23:0] LEFT_OUT,
  output logic               MUTED
);

  // gain is unsigned 0..UNITY, one bit wider than the fraction
  localparam int GW = GAIN_W + 1;
  // product width: 24-bit sample times a gain of at most 2**GAIN_W never exceeds this
  localparam int PW = 24 + GAIN_W;
  localparam logic [GAIN_W:0] UNITY  = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [GAIN_W:0] STEP_G = GW'(STEP);
  localparam logic [GAIN_W:0] GAIN_Z = '0;

  localparam int HW = $clog2(HOLD_FRAMES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  localparam int DW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_FRAMES - 1);
  localparam logic [DW-1:0] DEB_FULL = DW'(DEB_FRAMES);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  typedef enum logic [1:0] {
    S_PASS    = 2'd0,
    S_RAMP_DN = 2'd1,
    S_HOLD    = 2'd2,
    S_RAMP_UP = 2'd3
  } state_t;

`ifdef SOFT_START_EN
  localparam state_t          RST_STATE = S_HOLD;
  localparam logic [GAIN_W:0] RST_GAIN  = GAIN_Z;
`else
  localparam state_t          RST_STATE = S_PASS;
  localparam logic [GAIN_W:0] RST_GAIN  = UNITY;
`endif

  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [3:0]          r_cand;
  logic [DW-1:0]       r_deb_cnt;
  logic [3:0]          r_pending;

  state_t              r_state;
  logic [GAIN_W:0]     r_gain;
  logic [HW-1:0]       r_hold_cnt;
  logic [3:0]          r_switch_out;

  state_t              w_state_nxt;
  logic [GAIN_W:0]     w_gain_nxt;
  logic [HW-1:0]       w_hold_nxt;
  logic [3:0]          w_switch_nxt;
  logic                w_change;

  logic signed [PW-1:0] w_gain_ext;
  logic signed [PW-1:0] w_left_ext;
  logic signed [PW-1:0] w_right_ext;
  logic signed [PW-1:0] w_left_prod;
  logic signed [PW-1:0] w_right_prod;

  logic signed [23:0]  r_left_out;
  logic signed [23:0]  r_right_out;

  // two-flop synchroniser for the asynchronous board switches
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= SWITCH_IN;
      r_sync2 <= r_sync1;
    end
  end

  // debounce: any change restarts the count; DEB_FRAMES stable strobes promote the candidate
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_cand    <= 4'd0;
      r_deb_cnt <= '0;
      r_pending <= 4'd0;
    end else if (r_sync2 != r_cand) begin
      r_cand    <= r_sync2;
      r_deb_cnt <= '0;
    end else if (LEFT_RX_READY && (r_deb_cnt != DEB_FULL)) begin
      r_deb_cnt <= r_deb_cnt + DEB_ONE;
      if (r_deb_cnt == DEB_LAST) begin
        r_pending <= r_cand;
      end
    end
  end

  // the FSM always compares against the registered PENDING, so a same-edge update is seen a frame later
  assign w_change = (r_pending != r_switch_out);

  // next-state and gain: every transition happens on a frame strobe only
  always_comb begin
    w_state_nxt  = r_state;
    w_gain_nxt   = r_gain;
    w_hold_nxt   = r_hold_cnt;
    w_switch_nxt = r_switch_out;
    if (LEFT_RX_READY) begin
      case (r_state)
        S_PASS: begin
          w_gain_nxt = UNITY;
          if (w_change) begin
            w_state_nxt = S_RAMP_DN;
          end
        end
        S_RAMP_DN: begin
          if (r_gain <= STEP_G) begin
            w_gain_nxt   = GAIN_Z;
            w_state_nxt  = S_HOLD;
            w_switch_nxt = r_pending;
            w_hold_nxt   = '0;
          end else begin
            w_gain_nxt = r_gain - STEP_G;
          end
        end
        S_HOLD: begin
          w_gain_nxt = GAIN_Z;
          if (w_change) begin
            w_switch_nxt = r_pending;
            w_hold_nxt   = '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = S_RAMP_UP;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + HOLD_ONE;
          end
        end
        S_RAMP_UP: begin
          if (w_change) begin
            w_state_nxt = S_RAMP_DN;
          end else if (r_gain >= (UNITY - STEP_G)) begin
            w_gain_nxt  = UNITY;
            w_state_nxt = S_PASS;
          end else begin
            w_gain_nxt = r_gain + STEP_G;
          end
        end
        default: begin
          w_state_nxt = RST_STATE;
          w_gain_nxt  = RST_GAIN;
        end
      endcase
    end
  end

  // FSM, gain and filter-select registers
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_state      <= RST_STATE;
      r_gain       <= RST_GAIN;
      r_hold_cnt   <= '0;
      r_switch_out <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_gain       <= w_gain_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_switch_out <= w_switch_nxt;
    end
  end

  // signed sample times non-negative gain; the true product always fits in PW bits
  assign w_gain_ext   = $signed({{(PW - GW){1'b0}}, r_gain});
  assign w_left_ext   = $signed({{GAIN_W{LEFT_IN[23]}}, LEFT_IN});
  assign w_right_ext  = $signed({{GAIN_W{RIGHT_IN[23]}}, RIGHT_IN});
  assign w_left_prod  = w_left_ext * w_gain_ext;
  assign w_right_prod = w_right_ext * w_gain_ext;

  // gained samples registered every MCLK; arithmetic shift rounds toward -inf
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_left_out  <= 24'sd0;
      r_right_out <= 24'sd0;
    end else begin
      r_left_out  <= 24'(w_left_prod >>> GAIN_W);
      r_right_out <= 24'(w_right_prod >>> GAIN_W);
    end
  end

  assign SWITCH_OUT = r_switch_out;
  assign LEFT_OUT   = r_left_out;
  assign RIGHT_OUT  = r_right_out;
  assign MUTED      = (r_gain == GAIN_Z);

endmodule
